// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents: the default operand width and the controller state encoding.
package serial_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fa.sv
// Single-bit full adder used as the bit-serial datapath cell.
// Ports: a, b, cin  - addend bits and carry-in
//        sum, cout  - sum bit and carry-out
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub10.sv
// Bit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), LSB first,
// one bit per clock through a single full adder computing A + ~B + ~Bin.
// Ports: clk, reset (async, active-high)
//        start, A, B, Bin  - request and operands, sampled only while busy=0
//        Diff, Bout        - result and borrow-out, held from done to next start
//        busy              - high for the WIDTH shift cycles
//        done              - one-cycle pulse when Diff/Bout become valid
//        Ovf               - signed overflow, present only when
//                            SERIAL_SUB10_OVF_EN is defined
module serial_sub10
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB10_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_out;

   // Subtraction as addition of the inverted subtrahend; carry starts at ~Bin.
   fa u_fa (
      .a    (a_sh[0]),
      .b    (~b_sh[0]),
      .cin  (carry),
      .sum  (sum_bit),
      .cout (carry_out)
   );

   // Controller and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         Diff  <= '0;
         Bout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_SUB10_OVF_EN
         Ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= ~Bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               // Operands shift right so bit i is always at position 0;
               // result bits enter at the MSB and settle in place after WIDTH shifts.
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= carry_out;
               Diff  <= {sum_bit, Diff[WIDTH-1:1]};
               if (cnt == CW'(WIDTH - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  Bout  <= ~carry_out;
`ifdef SERIAL_SUB10_OVF_EN
                  // MSB stage: carry-in XOR carry-out flags signed overflow.
                  Ovf   <= carry ^ carry_out;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub10.sv
// Self-checking bench for serial_sub10: directed table, random operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_serial_sub10;

   localparam int unsigned W = 10;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB10_OVF_EN
   logic         Ovf;
`endif

   int tests;
   int failed;

   serial_sub10 #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .Diff  (Diff),
      .Bout  (Bout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_SUB10_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int unsigned bin;
      int unsigned diff;
      int unsigned bout;
   } vec_t;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic int unsigned ref_diff(int unsigned a, int unsigned b, int unsigned bin);
      int r;
      r = int'(a) - int'(b) - int'(bin);
      return int'(unsigned'(r) & 32'h3FF);
   endfunction

   function automatic int unsigned ref_bout(int unsigned a, int unsigned b, int unsigned bin);
      return (a < b + bin) ? 1 : 0;
   endfunction

   function automatic int unsigned ref_ovf(int unsigned a, int unsigned b, int unsigned bin);
      int sa;
      int sb;
      int r;
      sa = (a >= 512) ? int'(a) - 1024 : int'(a);
      sb = (b >= 512) ? int'(b) - 1024 : int'(b);
      r  = sa - sb - int'(bin);
      return (r < -512 || r > 511) ? 1 : 0;
   endfunction

   // Issue one operation from a negedge and follow it to the done cycle.
   // inj > 0 drives a competing start (A=1,B=1) during that busy cycle.
   task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                         input int unsigned bin, input int inj);
      int cyc;
      int busy_cnt;
      int done_at;
      int first_busy;
      A     = W'(a);
      B     = W'(b);
      Bin   = bin[0];
      start = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      cyc        = 1;
      busy_cnt   = 0;
      done_at    = 0;
      first_busy = int'(busy);
      while (cyc <= 30 && done_at == 0) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_at = cyc;
         end else begin
            if (cyc == inj) begin
               start = 1'b1;
               A     = W'(1);
               B     = W'(1);
               Bin   = 1'b0;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      chk({tag, " busy_c1"}, first_busy, 1);
      chk({tag, " done_cycle"}, done_at, W + 1);
      chk({tag, " busy_cycles"}, busy_cnt, W);
      chk({tag, " diff"}, Diff, ref_diff(a, b, bin));
      chk({tag, " bout"}, Bout, ref_bout(a, b, bin));
`ifdef SERIAL_SUB10_OVF_EN
      chk({tag, " ovf"}, Ovf, ref_ovf(a, b, bin));
`endif
   endtask

   vec_t vecs[$];

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      start  = 1'b0;
      A      = '0;
      B      = '0;
      Bin    = 1'b0;

      vecs.push_back('{100, 37, 0, 63, 0});
      vecs.push_back('{5, 9, 0, 1020, 1});
      vecs.push_back('{0, 0, 1, 1023, 1});
      vecs.push_back('{1023, 1023, 0, 0, 0});
      vecs.push_back('{511, 1023, 0, 512, 1});
      vecs.push_back('{0, 1, 0, 1023, 1});
      vecs.push_back('{512, 0, 1, 511, 0});

      @(negedge clk);
      @(negedge clk);
      chk("rst diff", Diff, 0);
      chk("rst bout", Bout, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
`ifdef SERIAL_SUB10_OVF_EN
      chk("rst ovf", Ovf, 0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Directed table; the spec values are checked against both the table and the model.
      foreach (vecs[i]) begin
         chk($sformatf("tbl%0d const", i), vecs[i].diff, ref_diff(vecs[i].a, vecs[i].b, vecs[i].bin));
         run_op($sformatf("tbl%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, 0);
         chk($sformatf("tbl%0d diff_tbl", i), Diff, vecs[i].diff);
         chk($sformatf("tbl%0d bout_tbl", i), Bout, vecs[i].bout);
         @(negedge clk);
      end

`ifdef SERIAL_SUB10_OVF_EN
      run_op("ovf_a", 511, 1023, 0, 0);
      chk("ovf_a ovf_const", Ovf, 1);
      @(negedge clk);
      run_op("ovf_b", 100, 37, 0, 0);
      chk("ovf_b ovf_const", Ovf, 0);
      @(negedge clk);
`endif

      // Competing start mid-run must be ignored.
      run_op("inj", 100, 37, 0, 4);
      chk("inj diff63", Diff, 63);
      // done is a single pulse; results hold while idle with changing inputs.
      A = W'(7);
      B = W'(3);
      @(negedge clk);
      chk("pulse done_low", done, 0);
      chk("hold diff", Diff, 63);
      chk("hold busy", busy, 0);
      @(negedge clk);
      chk("hold diff2", Diff, 63);
      chk("hold bout2", Bout, 0);

      // Back-to-back: second start issued in the done cycle of the first.
      run_op("b2b_1", 5, 9, 0, 0);
      run_op("b2b_2", 100, 37, 0, 0);
      @(negedge clk);

      // Reset during SHIFT cycle 5 abandons the operation.
      A     = W'(100);
      B     = W'(37);
      Bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst diff", Diff, 0);
      chk("mid_rst bout", Bout, 0);
      chk("mid_rst busy", busy, 0);
      chk("mid_rst done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int seen;
         seen = 0;
         repeat (15) begin
            @(negedge clk);
            if (done || busy) seen++;
         end
         chk("mid_rst no_done", seen, 0);
      end
      run_op("after_rst", 100, 37, 0, 0);
      @(negedge clk);

      // Random operands against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         int unsigned ra;
         int unsigned rb;
         int unsigned rc;
         ra = $urandom_range(0, 1023);
         rb = $urandom_range(0, 1023);
         rc = $urandom_range(0, 1);
         run_op($sformatf("rnd%0d", i), ra, rb, rc, (i % 3 == 0) ? int'($urandom_range(1, 9)) : 0);
         if (i % 2 == 0) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
